// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind the core's dcache port with fixed response latency.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcache_r_ena,
  input  logic        dcache_w_ena,
  input  logic        dcache_ext,
  input  logic [1:0]  dcache_width,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_data_in,
  output logic        dcache_valid,
  output logic [31:0] dcache_data_out,
`ifdef DMEM_MISALIGN_CHECK_EN
  output logic        dcache_misalign,
`endif
  output logic [1:0]  dbg_state
);

  // Handshake: a request (r_ena | w_ena) is taken only in IDLE; the core holds it
  // stable until dcache_valid, which pulses for exactly one cycle with the result.

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_w_q, op_w_d;
  logic [1:0]      width_q, width_d;
  logic            ext_q, ext_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            valid_q, valid_d;
  logic [31:0]     data_q, data_d;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic            mis_q, mis_d;
`endif

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req;
  logic            enter_resp;
  logic            acc_w;
  logic [1:0]      acc_width;
  logic            acc_ext;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic            acc_mis;
  logic [1:0]      lane;
  logic [31:0]     rd_word;
  logic [31:0]     shifted;
  logic [31:0]     load_val;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata;
  logic            ram_we;

  assign req = dcache_r_ena | dcache_w_ena;

  // With LATENCY=1 the commit edge is the accept edge, so the access is
  // described by the live inputs in IDLE and by the latched copy otherwise.
  always_comb begin
    acc_w     = op_w_q;
    acc_width = width_q;
    acc_ext   = ext_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_w     = dcache_w_ena;
      acc_width = dcache_width;
      acc_ext   = dcache_ext;
      acc_addr  = dcache_addr[AW+1:0];
      acc_wdata = dcache_data_in;
    end
  end

  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    acc_mis = ((acc_width == 2'b01) && acc_addr[0]) ||
              (acc_width[1] && (acc_addr[1:0] != 2'b00));
`else
    acc_mis = 1'b0;
`endif
    case (acc_width)
      2'b00:   lane = acc_addr[1:0];
      2'b01:   lane = {acc_addr[1], 1'b0};
      default: lane = 2'b00;
    endcase
    rd_word = mem[acc_addr[AW+1:2]];
    shifted = rd_word >> {lane, 3'b000};
    case (acc_width)
      2'b00: begin
        load_val  = acc_ext ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
        ram_be    = 4'b0001 << lane;
        ram_wdata = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        load_val  = acc_ext ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
        ram_be    = 4'b0011 << lane;
        ram_wdata = {2{acc_wdata[15:0]}};
      end
      default: begin
        load_val  = rd_word;
        ram_be    = 4'b1111;
        ram_wdata = acc_wdata;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_w_d     = op_w_q;
    width_d    = width_q;
    ext_d      = ext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    valid_d    = 1'b0;
    data_d     = 32'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis_d      = 1'b0;
`endif
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_w_d  = dcache_w_ena;
          width_d = dcache_width;
          ext_d   = dcache_ext;
          addr_d  = dcache_addr[AW+1:0];
          wdata_d = dcache_data_in;
          if (LATENCY == 1) begin
            state_d    = RESP;
            cnt_d      = '0;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        // The decrement to zero coincides with the edge that enters RESP.
        if (cnt_q <= CW'(1)) begin
          state_d    = RESP;
          cnt_d      = '0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      valid_d = 1'b1;
      data_d  = (acc_w || acc_mis) ? 32'd0 : load_val;
`ifdef DMEM_MISALIGN_CHECK_EN
      mis_d   = acc_mis;
`endif
    end
  end

  assign ram_we = enter_resp && acc_w && !acc_mis && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_w_q  <= 1'b0;
      width_q <= 2'b00;
      ext_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_w_q  <= op_w_d;
      width_q <= width_d;
      ext_q   <= ext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef DMEM_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[acc_addr[AW+1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  assign dcache_valid    = valid_q;
  assign dcache_data_out = data_q;
  assign dbg_state       = state_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign dcache_misalign = mis_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a word model predicts every response,
// a negedge monitor pops and compares. Honours DMEM_MISALIGN_CHECK_EN if defined.
module tb_dmem_responder;

  localparam int LATENCY     = 2;
  localparam int DEPTH_WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        dcache_r_ena, dcache_w_ena, dcache_ext;
  logic [1:0]  dcache_width;
  logic [31:0] dcache_addr, dcache_data_in;
  logic        dcache_valid;
  logic [31:0] dcache_data_out;
  logic [1:0]  dbg_state;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        dcache_misalign;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [0:0]  exp_mis_q[$];
  logic [31:0] model_mem [DEPTH_WORDS];

  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk             (clk),
    .rst             (rst),
    .dcache_r_ena    (dcache_r_ena),
    .dcache_w_ena    (dcache_w_ena),
    .dcache_ext      (dcache_ext),
    .dcache_width    (dcache_width),
    .dcache_addr     (dcache_addr),
    .dcache_data_in  (dcache_data_in),
    .dcache_valid    (dcache_valid),
    .dcache_data_out (dcache_data_out),
`ifdef DMEM_MISALIGN_CHECK_EN
    .dcache_misalign (dcache_misalign),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic is_mis(input logic [1:0] wd, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    return ((wd == 2'b01) && a[0]) || (wd[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] wd, input logic e, input logic [31:0] a);
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    word = model_mem[a[13:2]];
    case (wd)
      2'b00: begin
        case (a[1:0])
          2'd0: b = word[7:0];
          2'd1: b = word[15:8];
          2'd2: b = word[23:16];
          default: b = word[31:24];
        endcase
        return e ? {{24{b[7]}}, b} : {24'd0, b};
      end
      2'b01: begin
        h = a[1] ? word[31:16] : word[15:0];
        return e ? {{16{h[15]}}, h} : {16'd0, h};
      end
      default: return word;
    endcase
  endfunction

  task automatic model_store(input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] word;
    word = model_mem[a[13:2]];
    case (wd)
      2'b00: case (a[1:0])
        2'd0: word[7:0]   = d[7:0];
        2'd1: word[15:8]  = d[7:0];
        2'd2: word[23:16] = d[7:0];
        default: word[31:24] = d[7:0];
      endcase
      2'b01: if (a[1]) word[31:16] = d[15:0]; else word[15:0] = d[15:0];
      default: word = d;
    endcase
    model_mem[a[13:2]] = word;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    dcache_r_ena = 1'b0; dcache_w_ena = 1'b0; dcache_ext = 1'b0;
    dcache_width = 2'b00; dcache_addr = 32'd0; dcache_data_in = 32'd0;
  endtask

  task automatic drive(input logic w, input logic r, input logic [1:0] wd, input logic e,
                       input logic [31:0] a, input logic [31:0] d);
    logic mis;
    logic [31:0] exp;
    mis = is_mis(wd, a);
    if (w) begin
      if (!mis) model_store(wd, a, d);
      exp = 32'd0;
    end else begin
      exp = mis ? 32'd0 : model_load(wd, e, a);
    end
    exp_q.push_back(exp);
    exp_mis_q.push_back(mis);
    dcache_w_ena = w; dcache_r_ena = r; dcache_width = wd;
    dcache_ext = e; dcache_addr = a; dcache_data_in = d;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dcache_valid && n < 20);
    if (!dcache_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic access(input logic w, input logic r, input logic [1:0] wd, input logic e,
                        input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    drive(w, r, wd, e, a, d);
    wait_valid(n);
    check("latency", n, LATENCY);
    idle_inputs();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (dcache_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          check("resp_data", dcache_data_out, exp_q.pop_front());
`ifdef DMEM_MISALIGN_CHECK_EN
          check("resp_misalign", {31'd0, dcache_misalign}, {31'd0, exp_mis_q.pop_front()});
`else
          void'(exp_mis_q.pop_front());
`endif
        end
      end else begin
        check("idle_data_zero", dcache_data_out, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [1:0]  wd;
    logic [31:0] a;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, dcache_valid}, 32'd0);
    check("rst_data", dcache_data_out, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("rst_misalign", {31'd0, dcache_misalign}, 32'd0);
`endif
    rst = 1'b0;

    // word store / load
    access(1, 0, 2'b10, 0, 32'h100, 32'hDEADBEEF);
    access(0, 1, 2'b10, 0, 32'h100, 32'h0);
    check("word_plan", model_load(2'b10, 0, 32'h100), 32'hDEADBEEF);

    // byte / half extraction; r+w together is a store
    access(1, 1, 2'b10, 0, 32'h20, 32'h80FF7F01);
    access(0, 1, 2'b00, 1, 32'h21, 32'h0);
    access(0, 1, 2'b00, 1, 32'h22, 32'h0);
    access(0, 1, 2'b00, 1, 32'h23, 32'h0);
    access(0, 1, 2'b00, 0, 32'h23, 32'h0);
    access(0, 1, 2'b01, 1, 32'h22, 32'h0);
    access(0, 1, 2'b01, 0, 32'h20, 32'h0);
    access(0, 1, 2'b11, 1, 32'h20, 32'h0);

    // partial stores
    access(1, 0, 2'b10, 0, 32'h40, 32'h11223344);
    access(1, 0, 2'b00, 0, 32'h42, 32'hFFFFFFAA);
    access(0, 1, 2'b10, 0, 32'h40, 32'h0);
    check("partial_plan", model_load(2'b10, 0, 32'h40), 32'h11AA3344);
    access(1, 0, 2'b01, 0, 32'h40, 32'h0000BEEF);
    access(0, 1, 2'b10, 0, 32'h40, 32'h0);

    // back-to-back loads with request held high
    @(negedge clk);
    drive(0, 1, 2'b10, 0, 32'h100, 32'h0);
    wait_valid(n);
    check("b2b_first_lat", n, LATENCY);
    drive(0, 1, 2'b10, 0, 32'h40, 32'h0);
    wait_valid(n);
    check("b2b_gap", n, LATENCY + 1);
    idle_inputs();

    // wrap modulo RAM size
    access(1, 0, 2'b10, 0, 32'h4000, 32'hCAFEF00D);
    access(0, 1, 2'b10, 0, 32'h0, 32'h0);

    // reset on the commit edge of a store
    access(1, 0, 2'b10, 0, 32'h200, 32'h55AA55AA);
    @(negedge clk);
    dcache_w_ena = 1'b1; dcache_width = 2'b10; dcache_addr = 32'h200; dcache_data_in = 32'h12345678;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_valid", {31'd0, dcache_valid}, 32'd0);
    check("rstmid_data", dcache_data_out, 32'd0);
    check("rstmid_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    access(0, 1, 2'b10, 0, 32'h200, 32'h0);

    // misaligned word load
    access(0, 1, 2'b10, 0, 32'h102, 32'h0);
    access(1, 0, 2'b01, 0, 32'h101, 32'h00007777);
    access(0, 1, 2'b10, 0, 32'h100, 32'h0);

    // random traffic over a preloaded window
    for (int i = 0; i < 16; i++) access(1, 0, 2'b10, 0, 32'h300 + 4 * i, $urandom);
    for (int i = 0; i < 30; i++) begin
      wd = 2'($urandom_range(0, 3));
      a  = 32'h300 + $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) access(1, 0, wd, 0, a, $urandom);
      else access(0, 1, wd, 1'($urandom_range(0, 1)), a, 32'h0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
